// File: rtl/sayuru_mem_bridge.sv
// Memory-side bridge for the Sayuru cache: turns req/gnt/rvalid traffic into
// single-port synchronous BRAM accesses, with programmable wait states.
module sayuru_mem_bridge #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,  // fixed at 32: four byte lanes
  parameter int WAIT_CYCLES = 2    // 0..255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic [31:0]           req_count_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  state_t                  state_q, state_d;
  logic [7:0]              wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-3:0]   addr_q;
  logic                    we_q;
  logic [3:0]              be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [31:0]             req_count_q;

  // Byte selection is by be only; the low address bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr_i[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      req_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (data_gnt_o) begin
        addr_q      <= data_addr_i[ADDR_WIDTH-1:2];
        we_q        <= data_we_i;
        be_q        <= data_be_i;
        wdata_q     <= data_wdata_i;
        req_count_q <= req_count_q + 32'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_rdata_o  = '0;
    mem_en_o      = 1'b0;
    mem_we_o      = 4'b0000;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    unique case (state_q)
      IDLE: begin
        // Gated by rst: the async reset holds state in IDLE, but no grant may
        // be issued while reset is still asserted.
        data_gnt_o = data_req_i & ~rst;
        if (data_gnt_o) begin
          state_d    = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 8'd0) state_d = ACCESS;
        else                    wait_cnt_d = wait_cnt_q - 8'd1;
      end
      ACCESS: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q ? be_q : 4'b0000;
        mem_addr_o  = addr_q;
        mem_wdata_o = we_q ? wdata_q : '0;
        state_d     = RESP;
      end
      RESP: begin
        // BRAM read data arrives one cycle after mem_en, i.e. now.
        data_rvalid_o = 1'b1;
        data_rdata_o  = we_q ? '0 : mem_rdata_i;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign req_count_o = req_count_q;

endmodule

// File: tb/tb_sayuru_mem_bridge.sv
// Directed bench for sayuru_mem_bridge: one instance with 2 wait states and
// one with none, each backed by a small byte-enabled BRAM model.
module tb_sayuru_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;          // 0 = two-wait-state instance, 1 = zero-wait instance
  logic        req, we;
  logic [15:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_a, gnt_a, rvalid_a, en_a, busy_a;
  logic [31:0] rdata_a, mwdata_a, mrdata_a, cnt_a;
  logic [3:0]  mwe_a;
  logic [13:0] maddr_a;
  logic        req_b, gnt_b, rvalid_b, en_b, busy_b;
  logic [31:0] rdata_b, mwdata_b, mrdata_b, cnt_b;
  logic [3:0]  mwe_b;
  logic [13:0] maddr_b;

  assign req_a = req & ~sel;
  assign req_b = req & sel;

  sayuru_mem_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .data_req_i(req_a), .data_gnt_o(gnt_a),
    .data_rvalid_o(rvalid_a), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
    .data_wdata_i(wdata), .data_rdata_o(rdata_a), .mem_en_o(en_a), .mem_we_o(mwe_a),
    .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a), .mem_rdata_i(mrdata_a),
    .busy_o(busy_a), .req_count_o(cnt_a));

  sayuru_mem_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .data_req_i(req_b), .data_gnt_o(gnt_b),
    .data_rvalid_o(rvalid_b), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
    .data_wdata_i(wdata), .data_rdata_o(rdata_b), .mem_en_o(en_b), .mem_we_o(mwe_b),
    .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b), .mem_rdata_i(mrdata_b),
    .busy_o(busy_b), .req_count_o(cnt_b));

  logic [31:0] ram_a [0:255];
  logic [31:0] ram_b [0:255];

  always @(posedge clk) begin
    if (en_a) begin
      for (int b = 0; b < 4; b++)
        if (mwe_a[b]) ram_a[maddr_a[7:0]][8*b +: 8] <= mwdata_a[8*b +: 8];
      mrdata_a <= ram_a[maddr_a[7:0]];
    end
    if (en_b) begin
      for (int b = 0; b < 4; b++)
        if (mwe_b[b]) ram_b[maddr_b[7:0]][8*b +: 8] <= mwdata_b[8*b +: 8];
      mrdata_b <= ram_b[maddr_b[7:0]];
    end
  end

  wire        gnt    = sel ? gnt_b    : gnt_a;
  wire        rvalid = sel ? rvalid_b : rvalid_a;
  wire        en     = sel ? en_b     : en_a;
  wire        busy   = sel ? busy_b   : busy_a;
  wire [3:0]  mwe    = sel ? mwe_b    : mwe_a;
  wire [13:0] maddr  = sel ? maddr_b  : maddr_a;
  wire [31:0] mwdata = sel ? mwdata_b : mwdata_a;
  wire [31:0] rdata  = sel ? rdata_b  : rdata_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered in the low clock phase; issues one transaction on the selected
  // instance and checks its timing and RAM-side/response values.
  task automatic do_txn(input logic [15:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    int t0, n, acc_lat, rv_lat, wc;
    logic [3:0]  we_s;
    logic [13:0] ad_s;
    logic [31:0] wd_s, rd_s;
    wc = sel ? 0 : 2;
    addr = a; we = w; be = b; wdata = d; req = 1'b1;
    #1;
    n = 0;
    while (!gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant", {31'd0, gnt}, 32'd1);
    t0 = cyc; acc_lat = -1; rv_lat = -1;
    we_s = 'x; ad_s = 'x; wd_s = 'x; rd_s = 'x;
    for (int i = 0; i < 20 && rv_lat < 0; i++) begin
      @(negedge clk); req = 1'b0; #1;
      if (en && acc_lat < 0) begin
        acc_lat = cyc - t0; we_s = mwe; ad_s = maddr; wd_s = mwdata;
      end
      if (rvalid) begin
        rv_lat = cyc - t0; rd_s = rdata;
        check("busy_at_rvalid", {31'd0, busy}, 32'd1);
      end
    end
    check("access_latency", acc_lat, wc + 1);
    check("rvalid_latency", rv_lat, wc + 2);
    check("mem_we", {28'd0, we_s}, w ? {28'd0, b} : 32'd0);
    check("mem_addr", {18'd0, ad_s}, {18'd0, a[15:2]});
    if (w) check("mem_wdata", wd_s, d);
    check("rdata", rd_s, w ? 32'd0 : exp_rd);
    @(negedge clk); #1;
    check("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, nrv, n_en, n_rv;
    int gcyc [0:2];

    // Reset held 3 cycles with a request pending.
    sel = 1'b0; rst = 1'b1; req = 1'b1; addr = 16'h0010; we = 1'b1; be = 4'hF;
    wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_gnt", {31'd0, gnt_a}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid_a}, 32'd0);
      check("rst_mem_en", {31'd0, en_a}, 32'd0);
      check("rst_req_count", cnt_a, 32'd0);
      @(negedge clk);
    end
    rst = 1'b0; #1;
    check("gnt_after_rst", {31'd0, gnt_a}, 32'd1);

    // Write then read with two wait states.
    do_txn(16'h0010, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0);
    do_txn(16'h0010, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF);

    // Partial write into a known word, plus a be=0 write that must not modify it.
    do_txn(16'h0020, 1'b1, 4'hF, 32'h11223344, 32'h0);
    do_txn(16'h0022, 1'b1, 4'h2, 32'h0000AB00, 32'h0);
    do_txn(16'h0020, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0);
    do_txn(16'h0020, 1'b0, 4'hF, 32'h0, 32'h1122AB44);
    check("req_count_6", cnt_a, 32'd6);

    // Back-to-back reads with req held high.
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0;
    addr = 16'h0010; we = 1'b0; be = 4'hF; req = 1'b1; ng = 0; nrv = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (ng == 3) req = 1'b0;
      #1;
      if (gnt_a) begin
        if (ng < 3) gcyc[ng] = cyc;
        ng++;
      end
      if (rvalid_a) begin
        nrv++;
        check("b2b_rdata", rdata_a, 32'hDEADBEEF);
      end
    end
    check("b2b_grants", ng, 3);
    check("b2b_rvalids", nrv, 3);
    check("b2b_gap0", gcyc[1] - gcyc[0], 5);
    check("b2b_gap1", gcyc[2] - gcyc[1], 5);
    check("b2b_req_count", cnt_a, 32'd3);

    // Reset while the transaction sits in WAIT.
    @(negedge clk); addr = 16'h0020; we = 1'b0; req = 1'b1; #1;
    check("midrst_gnt", {31'd0, gnt_a}, 32'd1);
    @(negedge clk); req = 1'b0; #1;
    check("midrst_busy_wait", {31'd0, busy_a}, 32'd1);
    rst = 1'b1; #1;
    check("midrst_busy_clr", {31'd0, busy_a}, 32'd0);
    check("midrst_cnt_clr", cnt_a, 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    n_en = 0; n_rv = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (en_a) n_en++;
      if (rvalid_a) n_rv++;
      @(negedge clk);
    end
    check("midrst_no_mem_en", n_en, 0);
    check("midrst_no_rvalid", n_rv, 0);
    check("midrst_busy_idle", {31'd0, busy_a}, 32'd0);

    // Zero wait states: rvalid two cycles after grant.
    sel = 1'b1;
    do_txn(16'h0040, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0);
    do_txn(16'h0040, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D);
    check("zw_req_count", cnt_b, 32'd2);

    // Grant counter wraps from all-ones to zero.
    sel = 1'b0;
    force dut_a.req_count_q = 32'hFFFFFFFF;
    #1;
    release dut_a.req_count_q;
    #1;
    check("wrap_preset", cnt_a, 32'hFFFFFFFF);
    do_txn(16'h0010, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF);
    check("wrap_req_count", cnt_a, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
